// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin owner of one SPI engine among NUM_REQ requesters.
// Ports: clk/reset_n/enable, req/req_wdata in; grant/ack/err/rdata/busy out;
// spi_go/spi_wdata to the engine, spi_ready/spi_rdata back (ready is async).
module spi_xfer_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_W         = 32,
  parameter int GO_CYCLES      = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      spi_go,
  output logic [DATA_W-1:0]         spi_wdata,
  input  logic                      spi_ready,
  input  logic [DATA_W-1:0]         spi_rdata
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_DONE
  } state_t;

  state_t              r_state, w_state;
  logic                r_s1, r_s2, r_s2_prev;
  logic [IW-1:0]       r_rr, w_rr;
  logic [IW-1:0]       r_win, w_win;
  logic [3:0]          r_go_cnt, w_go_cnt;
  logic [TW-1:0]       r_to_cnt, w_to_cnt;
  logic                r_done_seen, w_done_seen;
  logic [NUM_REQ-1:0]  r_grant, w_grant;
  logic [NUM_REQ-1:0]  r_ack, w_ack;
  logic                r_err, w_err;
  logic                r_go, w_go;
  logic [DATA_W-1:0]   r_rdata, w_rdata;
  logic [DATA_W-1:0]   r_wdata, w_wdata;

  logic                w_done_evt;
  logic                w_found;
  logic [IW-1:0]       w_pick;
  logic [IW-1:0]       w_idx;
  logic [NUM_REQ-1:0]  w_onehot;
  logic [DATA_W-1:0]   w_words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign w_words[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  // Falling edge of the synchronised ready line marks completion.
  assign w_done_evt = r_s2_prev & ~r_s2;
  assign w_onehot   = NUM_REQ'(1) << r_win;

  // Search starts one past the last owner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IW'((int'(r_rr) + k) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_state     = r_state;
    w_rr        = r_rr;
    w_win       = r_win;
    w_go_cnt    = r_go_cnt;
    w_to_cnt    = r_to_cnt;
    w_done_seen = r_done_seen;
    w_grant     = r_grant;
    w_ack       = r_ack;
    w_err       = r_err;
    w_go        = r_go;
    w_rdata     = r_rdata;
    w_wdata     = r_wdata;
    if (!enable) begin
      w_state     = S_IDLE;
      w_go        = 1'b0;
      w_grant     = '0;
      w_ack       = '0;
      w_err       = 1'b0;
      w_go_cnt    = '0;
      w_to_cnt    = '0;
      w_done_seen = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            w_win       = w_pick;
            w_grant     = NUM_REQ'(1) << w_pick;
            w_wdata     = w_words[w_pick];
            w_go        = 1'b1;
            w_go_cnt    = 4'(GO_CYCLES - 1);
            w_done_seen = 1'b0;
            w_state     = S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          // The engine may finish before spi_go drops; remember it.
          if (w_done_evt) w_done_seen = 1'b1;
          if (r_go_cnt == 4'd0) begin
            w_go    = 1'b0;
            w_state = S_WAIT;
          end else begin
            w_go_cnt = r_go_cnt - 4'd1;
          end
        end
        S_WAIT: begin
          if (w_done_evt || r_done_seen) begin
            w_rdata = spi_rdata;
            w_ack   = w_onehot;
            w_err   = 1'b0;
            w_state = S_DONE;
          end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            w_rdata = '0;
            w_ack   = w_onehot;
            w_err   = 1'b1;
            w_state = S_DONE;
          end else begin
            w_to_cnt = r_to_cnt + 1'b1;
          end
        end
        S_DONE: begin
          w_ack       = '0;
          w_err       = 1'b0;
          w_grant     = '0;
          w_rr        = r_win;
          w_to_cnt    = '0;
          w_done_seen = 1'b0;
          w_state     = S_IDLE;
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s2_prev   <= 1'b0;
      r_rr        <= IW'(NUM_REQ - 1);
      r_win       <= '0;
      r_go_cnt    <= '0;
      r_to_cnt    <= '0;
      r_done_seen <= 1'b0;
      r_grant     <= '0;
      r_ack       <= '0;
      r_err       <= 1'b0;
      r_go        <= 1'b0;
      r_rdata     <= '0;
      r_wdata     <= '0;
    end else begin
      r_s1        <= spi_ready;
      r_s2        <= r_s1;
      r_s2_prev   <= r_s2;
      r_state     <= w_state;
      r_rr        <= w_rr;
      r_win       <= w_win;
      r_go_cnt    <= w_go_cnt;
      r_to_cnt    <= w_to_cnt;
      r_done_seen <= w_done_seen;
      r_grant     <= w_grant;
      r_ack       <= w_ack;
      r_err       <= w_err;
      r_go        <= w_go;
      r_rdata     <= w_rdata;
      r_wdata     <= w_wdata;
    end
  end

  assign grant     = r_grant;
  assign ack       = r_ack;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign busy      = (r_state != S_IDLE);
  assign spi_go    = r_go;
  assign spi_wdata = r_wdata;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter: directed scenarios for spi_xfer_arbiter.
// NUM_REQ=2, GO_CYCLES=2, TIMEOUT_CYCLES=16.
module tb_spi_xfer_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  req;
  logic [63:0] req_wdata;
  logic [1:0]  grant;
  logic [1:0]  ack;
  logic        err;
  logic [31:0] rdata;
  logic        busy;
  logic        spi_go;
  logic [31:0] spi_wdata;
  logic        spi_ready;
  logic [31:0] spi_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  spi_xfer_arbiter #(
    .NUM_REQ(2), .DATA_W(32), .GO_CYCLES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .req(req), .req_wdata(req_wdata),
    .grant(grant), .ack(ack), .err(err), .rdata(rdata),
    .busy(busy), .spi_go(spi_go), .spi_wdata(spi_wdata),
    .spi_ready(spi_ready), .spi_rdata(spi_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    repeat (3) tick;
  endtask

  task automatic wait_grant(output int cyc);
    cyc = 0;
    while (grant == 2'b00 && cyc < 10) begin
      tick;
      cyc++;
    end
  endtask

  task automatic wait_go_low(output int cyc);
    cyc = 0;
    while (spi_go && cyc < 20) begin
      tick;
      cyc++;
    end
  endtask

  task automatic wait_ack(input int maxc, output int cyc,
                          output bit seen, output bit stray);
    cyc = 0;
    seen = 1'b0;
    stray = 1'b0;
    while (!seen && cyc < maxc) begin
      tick;
      cyc++;
      if ((ack & ~grant) != 2'b00) stray = 1'b1;
      if (ack != 2'b00) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; enable = 1'b0; req = 2'b00;
    req_wdata = 64'h0; spi_ready = 1'b1; spi_rdata = 32'h0;
    repeat (2) tick;
    n_tests++;
    if ({grant, ack, err, busy, spi_go, rdata, spi_wdata} !== 71'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got grant=%b ack=%b err=%b busy=%b go=%b rdata=%h wdata=%h want all 0",
               grant, ack, err, busy, spi_go, rdata, spi_wdata);
    end
    reset_n = 1'b1;
    repeat (3) tick;
    n_tests++;
    if ({busy, ack} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release: got busy=%b ack=%b want 0 0", busy, ack);
    end
  endtask

  task automatic test_single;
    int c; bit seen, stray;
    spi_rdata = 32'h1234_5678;
    req_wdata = {32'hDEAD_0002, 32'hA5A5_0001};
    enable = 1'b1;
    req = 2'b01;
    tick;
    n_tests++;
    if ({grant, spi_go, spi_wdata} !== {2'b01, 1'b1, 32'hA5A5_0001}) begin
      n_fail++;
      $display("FAIL single_grant: got grant=%b go=%b wdata=%h want 01 1 a5a50001",
               grant, spi_go, spi_wdata);
    end
    req_wdata[31:0] = 32'h0;
    wait_go_low(c);
    n_tests++;
    if (c !== 2) begin
      n_fail++;
      $display("FAIL single_go_width: got %0d want 2", c);
    end
    repeat (8) tick;
    spi_ready = 1'b0;
    wait_ack(10, c, seen, stray);
    n_tests++;
    if ({seen, stray, ack, err, busy} !== {1'b1, 1'b0, 2'b01, 1'b0, 1'b1} || c != 3) begin
      n_fail++;
      $display("FAIL single_ack: got seen=%b stray=%b ack=%b err=%b busy=%b lat=%0d want 1 0 01 0 1 3",
               seen, stray, ack, err, busy, c);
    end
    n_tests++;
    if (rdata !== 32'h1234_5678 || spi_wdata !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL single_data: got rdata=%h wdata=%h want 12345678 a5a50001", rdata, spi_wdata);
    end
    req = 2'b00;
    spi_ready = 1'b1;
    req_wdata[31:0] = 32'hA5A5_0001;
    tick;
    n_tests++;
    if ({ack, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL single_end: got ack=%b busy=%b want 00 0", ack, busy);
    end
  endtask

  task automatic test_round_robin;
    int c; bit seen, stray;
    logic [1:0] exp;
    req = 2'b00;
    do_reset;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      wait_grant(c);
      n_tests++;
      if (grant !== exp) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got %b want %b", i, grant, exp);
      end
      wait_go_low(c);
      repeat (2) tick;
      spi_ready = 1'b0;
      wait_ack(10, c, seen, stray);
      n_tests++;
      if ({seen, stray, ack} !== {1'b1, 1'b0, exp}) begin
        n_fail++;
        $display("FAIL rr_ack%0d: got seen=%b stray=%b ack=%b want 1 0 %b",
                 i, seen, stray, ack, exp);
      end
      spi_ready = 1'b1;
      tick;
    end
    req = 2'b00;
    tick;
  endtask

  task automatic test_timeout;
    int c; bit seen, stray;
    spi_ready = 1'b1;
    req = 2'b01;
    wait_grant(c);
    n_tests++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("FAIL to_grant: got %b want 01", grant);
    end
    wait_go_low(c);
    wait_ack(30, c, seen, stray);
    n_tests++;
    if ({seen, ack, err, busy} !== {1'b1, 2'b01, 1'b1, 1'b1} || c != 16) begin
      n_fail++;
      $display("FAIL to_ack: got seen=%b ack=%b err=%b busy=%b lat=%0d want 1 01 1 1 16",
               seen, ack, err, busy, c);
    end
    n_tests++;
    if (rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL to_rdata: got %h want 0", rdata);
    end
    req = 2'b00;
    tick;
    n_tests++;
    if ({busy, ack, err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL to_end: got busy=%b ack=%b err=%b want 0 00 0", busy, ack, err);
    end
  endtask

  task automatic test_early;
    int c; bit seen, stray;
    spi_rdata = 32'hCAFE_F00D;
    req = 2'b10;
    spi_ready = 1'b0;
    tick;
    n_tests++;
    if (grant !== 2'b10) begin
      n_fail++;
      $display("FAIL early_grant: got %b want 10", grant);
    end
    wait_go_low(c);
    wait_ack(20, c, seen, stray);
    n_tests++;
    if ({seen, ack, err} !== {1'b1, 2'b10, 1'b0} || c != 1) begin
      n_fail++;
      $display("FAIL early_ack: got seen=%b ack=%b err=%b lat=%0d want 1 10 0 1",
               seen, ack, err, c);
    end
    n_tests++;
    if (rdata !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL early_rdata: got %h want cafef00d", rdata);
    end
    req = 2'b00;
    spi_ready = 1'b1;
    repeat (3) tick;
  endtask

  task automatic test_coincide;
    int c; bit seen, stray;
    spi_rdata = 32'h0BAD_BEEF;
    req = 2'b01;
    wait_grant(c);
    wait_go_low(c);
    repeat (13) tick;
    spi_ready = 1'b0;
    wait_ack(10, c, seen, stray);
    n_tests++;
    if ({seen, ack, err} !== {1'b1, 2'b01, 1'b0} || c != 3) begin
      n_fail++;
      $display("FAIL coincide_ack: got seen=%b ack=%b err=%b lat=%0d want 1 01 0 3",
               seen, ack, err, c);
    end
    n_tests++;
    if (rdata !== 32'h0BAD_BEEF) begin
      n_fail++;
      $display("FAIL coincide_rdata: got %h want 0badbeef", rdata);
    end
    req = 2'b00;
    spi_ready = 1'b1;
    repeat (3) tick;
  endtask

  task automatic test_abort;
    int c; bit seen, stray, any_ack;
    req = 2'b10;
    wait_grant(c);
    n_tests++;
    if (grant !== 2'b10) begin
      n_fail++;
      $display("FAIL abort_grant: got %b want 10", grant);
    end
    wait_go_low(c);
    repeat (3) tick;
    enable = 1'b0;
    tick;
    n_tests++;
    if ({busy, spi_go, grant, ack} !== 6'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b go=%b grant=%b ack=%b want 0 0 00 00",
               busy, spi_go, grant, ack);
    end
    any_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (ack != 2'b00) any_ack = 1'b1;
    end
    n_tests++;
    if (any_ack !== 1'b0 || rdata !== 32'h0BAD_BEEF) begin
      n_fail++;
      $display("FAIL abort_noack: got ack_seen=%b rdata=%h want 0 0badbeef", any_ack, rdata);
    end
    req = 2'b11;
    enable = 1'b1;
    wait_grant(c);
    n_tests++;
    if (grant !== 2'b10) begin
      n_fail++;
      $display("FAIL abort_regrant: got %b want 10", grant);
    end
    wait_go_low(c);
    repeat (2) tick;
    spi_ready = 1'b0;
    wait_ack(10, c, seen, stray);
    n_tests++;
    if ({seen, stray, ack, err} !== {1'b1, 1'b0, 2'b10, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_resume_ack: got seen=%b stray=%b ack=%b err=%b want 1 0 10 0",
               seen, stray, ack, err);
    end
    req = 2'b00;
    spi_ready = 1'b1;
    repeat (3) tick;
  endtask

  task automatic test_reset_mid;
    int c; bit seen, stray;
    req = 2'b01;
    wait_grant(c);
    n_tests++;
    if ({grant, spi_go} !== 3'b011) begin
      n_fail++;
      $display("FAIL rst_pre: got grant=%b go=%b want 01 1", grant, spi_go);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({grant, ack, err, busy, spi_go, rdata, spi_wdata} !== 71'h0) begin
      n_fail++;
      $display("FAIL rst_async: got grant=%b ack=%b err=%b busy=%b go=%b rdata=%h wdata=%h want all 0",
               grant, ack, err, busy, spi_go, rdata, spi_wdata);
    end
    tick;
    reset_n = 1'b1;
    req = 2'b11;
    wait_grant(c);
    n_tests++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_first_grant: got %b want 01", grant);
    end
    wait_go_low(c);
    wait_ack(30, c, seen, stray);
    n_tests++;
    if ({seen, ack, err} !== {1'b1, 2'b01, 1'b1} || c != 16) begin
      n_fail++;
      $display("FAIL rst_no_false_done: got seen=%b ack=%b err=%b lat=%0d want 1 01 1 16",
               seen, ack, err, c);
    end
    req = 2'b00;
    repeat (2) tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_timeout;
    test_early;
    test_coincide;
    test_abort;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
